// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping-coherence instruction issuer: field layout,
// the block address map and the issue FSM states.
package snoop_pkg;

   localparam int CPU_MSB  = 15;
   localparam int CPU_LSB  = 14;
   localparam int OP_BIT   = 13;
   localparam int ADDR_MSB = 12;
   localparam int ADDR_LSB = 8;

   localparam logic [1:0] CPU_INVALID = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Only the even blocks 8..18 exist in the coherence top's memory map.
   function automatic logic addr_unmapped(input logic [15:0] instr);
      case (instr[ADDR_MSB:ADDR_LSB])
         5'd8, 5'd10, 5'd12, 5'd14, 5'd16, 5'd18: return 1'b0;
         default:                                  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/snoop_instr_fifo.sv
// Instruction FIFO: DEPTH x WIDTH storage with wrap-bit pointers and a
// combinational head so the issuer can pop and capture in the same cycle.
module snoop_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_en;
   logic             pop_en;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign head    = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clock) begin
      if (push_en) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (pop_en)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/snoop_instr_issuer.sv
// Buffers coherence instructions and issues them one at a time, holding each
// until the coherence top reports completion or the wait window expires.
module snoop_instr_issuer
   import snoop_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [15:0]      in_instr,
   output logic             in_ready,
   output logic             issue_valid,
   output logic [15:0]      issue_instr,
   output logic             issue_unmapped,
   input  logic             issue_done,
   output logic             busy,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] tmo_cnt
);

   localparam int WAIT_W = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t            state_reg, state_next;
   logic [15:0]       issue_instr_reg;
   logic              unmapped_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [CNT_W-1:0]  drop_cnt_reg;
   logic [CNT_W-1:0]  tmo_cnt_reg;

   logic        fifo_full, fifo_empty;
   logic [15:0] fifo_head;
   logic        accept, drop, fifo_push, fifo_pop;
   logic        load, wait_clr, wait_inc, tmo_inc;

   assign accept    = in_valid && !fifo_full;
   assign drop      = accept && (in_instr[CPU_MSB:CPU_LSB] == CPU_INVALID);
   assign fifo_push = accept && !drop;

   snoop_instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (in_instr),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_next = state_reg;
      fifo_pop   = 1'b0;
      load       = 1'b0;
      wait_clr   = 1'b0;
      wait_inc   = 1'b0;
      tmo_inc    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               load       = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            wait_clr   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            // Completion wins over a timeout landing in the same cycle.
            if (issue_done) begin
               state_next = IDLE;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               tmo_inc    = 1'b1;
               state_next = IDLE;
            end else begin
               wait_inc = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         issue_instr_reg <= '0;
         unmapped_reg    <= 1'b0;
         wait_cnt_reg    <= '0;
         drop_cnt_reg    <= '0;
         tmo_cnt_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (load) begin
            issue_instr_reg <= fifo_head;
            unmapped_reg    <= addr_unmapped(fifo_head);
         end
         if (wait_clr) begin
            wait_cnt_reg <= '0;
         end else if (wait_inc) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
         end
         if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
         end
         if (tmo_inc && (tmo_cnt_reg != '1)) begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign in_ready       = !fifo_full;
   assign issue_valid    = (state_reg == ISSUE);
   assign issue_instr    = issue_instr_reg;
   assign issue_unmapped = unmapped_reg;
   assign busy           = (state_reg != IDLE) || !fifo_empty;
   assign drop_cnt       = drop_cnt_reg;
   assign tmo_cnt        = tmo_cnt_reg;

endmodule

// File: tb/tb_snoop_instr_issuer.sv
// Self-checking bench for snoop_instr_issuer: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_snoop_instr_issuer;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [15:0]      in_instr;
   logic             in_ready;
   logic             issue_valid;
   logic [15:0]      issue_instr;
   logic             issue_unmapped;
   logic             issue_done;
   logic             busy;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] tmo_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   snoop_instr_issuer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_instr       (in_instr),
      .in_ready       (in_ready),
      .issue_valid    (issue_valid),
      .issue_instr    (issue_instr),
      .issue_unmapped (issue_unmapped),
      .issue_done     (issue_done),
      .busy           (busy),
      .drop_cnt       (drop_cnt),
      .tmo_cnt        (tmo_cnt)
   );

   always #5 clock = ~clock;

   // Reference model: a queue of pending words plus the age of the one in flight
   // (age 0 = the issue cycle, ages 1..TIMEOUT = the wait window).
   logic [15:0] m_q[$];
   bit          m_active;
   int          m_age;
   logic [15:0] m_cur;
   bit          m_unm;
   int          m_drop;
   int          m_tmo;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   function automatic bit model_unmapped(input logic [15:0] w);
      int a;
      a = int'(w[12:8]);
      return !(a >= 8 && a <= 18 && (a % 2) == 0);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_active = 0;
      m_age    = 0;
      m_cur    = '0;
      m_unm    = 0;
      m_drop   = 0;
      m_tmo    = 0;
   endtask

   task automatic model_edge(input logic v, input logic [15:0] w, input logic d);
      bit xfer;
      xfer = v && (m_q.size() < DEPTH);
      if (m_active) begin
         if (m_age == 0) begin
            m_age = 1;
         end else if (d) begin
            m_active = 0;
         end else if (m_age == TIMEOUT) begin
            if (m_tmo < CNT_MAX) m_tmo++;
            m_active = 0;
         end else begin
            m_age++;
         end
      end else if (m_q.size() > 0) begin
         m_cur    = m_q.pop_front();
         m_unm    = model_unmapped(m_cur);
         m_active = 1;
         m_age    = 0;
      end
      if (xfer) begin
         if (w[15:14] == 2'b11) begin
            if (m_drop < CNT_MAX) m_drop++;
         end else begin
            m_q.push_back(w);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".in_ready"},    32'(in_ready),       32'(m_q.size() < DEPTH));
      chk({tag, ".issue_valid"}, 32'(issue_valid),    32'(m_active && m_age == 0));
      chk({tag, ".issue_instr"}, 32'(issue_instr),    32'(m_cur));
      chk({tag, ".unmapped"},    32'(issue_unmapped), 32'(m_unm));
      chk({tag, ".busy"},        32'(busy),           32'(m_active || m_q.size() > 0));
      chk({tag, ".drop_cnt"},    32'(drop_cnt),       32'(m_drop));
      chk({tag, ".tmo_cnt"},     32'(tmo_cnt),        32'(m_tmo));
   endtask

   // Drive at the falling edge, let one rising edge pass, compare at the next fall.
   task automatic step(input string tag, input logic v, input logic [15:0] w, input logic d);
      in_valid   = v;
      in_instr   = w;
      issue_done = d;
      @(posedge clock);
      model_edge(v, w, d);
      @(negedge clock);
      check_all(tag);
   endtask

   typedef struct {
      logic        v;
      logic [15:0] w;
      logic        d;
      logic        e_valid;
      logic [15:0] e_instr;
      logic        e_unm;
      logic        e_busy;
      logic [7:0]  e_drop;
   } vec_t;

   vec_t tbl [5];

   initial begin
      bit saw_full;
      int tmo_before;

      tbl[0] = '{1'b1, 16'h0A2F, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'd0};
      tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0A2F, 1'b0, 1'b1, 8'd0};
      tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0A2F, 1'b0, 1'b1, 8'd0};
      tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0A2F, 1'b0, 1'b0, 8'd0};
      tbl[4] = '{1'b1, 16'hC855, 1'b0, 1'b0, 16'h0A2F, 1'b0, 1'b0, 8'd1};

      reset      = 1'b0;
      in_valid   = 1'b0;
      in_instr   = '0;
      issue_done = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      check_all("reset");
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.busy",     32'(busy),     32'd0);
      reset = 1'b1;
      @(negedge clock);
      check_all("post_reset");

      // Single issue with done, then a rejected cpu==3 word.
      for (int i = 0; i < 5; i++) begin
         step("tbl", tbl[i].v, tbl[i].w, tbl[i].d);
         chk($sformatf("tbl%0d.valid", i), 32'(issue_valid),    32'(tbl[i].e_valid));
         chk($sformatf("tbl%0d.instr", i), 32'(issue_instr),    32'(tbl[i].e_instr));
         chk($sformatf("tbl%0d.unm", i),   32'(issue_unmapped), 32'(tbl[i].e_unm));
         chk($sformatf("tbl%0d.busy", i),  32'(busy),           32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d.drop", i),  32'(drop_cnt),       32'(tbl[i].e_drop));
      end

      // Unmapped address (19) is flagged and held through the wait window.
      step("unm_push", 1'b1, 16'h5355, 1'b0);
      step("unm_issue", 1'b0, 16'h0000, 1'b0);
      chk("unm.issue", 32'(issue_unmapped), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step("unm_wait", 1'b0, 16'h0000, 1'b0);
         chk("unm.hold", 32'(issue_unmapped), 32'd1);
         chk("unm.instr", 32'(issue_instr), 32'h5355);
      end
      step("unm_done", 1'b0, 16'h0000, 1'b1);
      chk("unm.idle", 32'(busy), 32'd0);

      // Overfill with no completions: fifo fills, extra word lost, all time out.
      tmo_before = m_tmo;
      saw_full   = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         step("fill", 1'b1, {3'b000, 5'd12, 8'(i)}, 1'b0);
         if (!in_ready) saw_full = 1;
      end
      chk("fill.full_seen", 32'(saw_full), 32'd1);
      for (int i = 0; i < 400 && busy; i++) begin
         step("drain", 1'b0, 16'h0000, 1'b0);
      end
      chk("drain.busy", 32'(busy), 32'd0);
      chk("drain.tmo", 32'(tmo_cnt), 32'(tmo_before + DEPTH + 1));

      // Done on the last wait cycle counts as completion; done while idle is ignored.
      tmo_before = m_tmo;
      step("edge_push", 1'b1, 16'h0A2F, 1'b0);
      step("edge_issue", 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < TIMEOUT; i++) begin
         step("edge_wait", 1'b0, 16'h0000, 1'b0);
      end
      chk("edge.pending", 32'(busy), 32'd1);
      step("edge_done", 1'b0, 16'h0000, 1'b1);
      chk("edge.idle", 32'(busy), 32'd0);
      chk("edge.tmo", 32'(tmo_cnt), 32'(tmo_before));
      for (int i = 0; i < 3; i++) begin
         step("idle_done", 1'b0, 16'h0000, 1'b1);
         chk("idle_done.valid", 32'(issue_valid), 32'd0);
      end

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         step("rand", 1'($urandom_range(0, 1)), w, ($urandom_range(0, 7) == 0));
      end

      // Async reset in the middle of a wait with two words queued.
      step("rst_p0", 1'b1, 16'h0811, 1'b0);
      step("rst_p1", 1'b1, 16'h4C22, 1'b0);
      step("rst_p2", 1'b1, 16'h9033, 1'b0);
      for (int i = 0; i < 400 && !issue_valid; i++) begin
         step("rst_wait_issue", 1'b0, 16'h0000, 1'b0);
      end
      step("rst_in_wait", 1'b0, 16'h0000, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("arst.valid",    32'(issue_valid),    32'd0);
      chk("arst.instr",    32'(issue_instr),    32'd0);
      chk("arst.unmapped", 32'(issue_unmapped), 32'd0);
      chk("arst.busy",     32'(busy),           32'd0);
      chk("arst.in_ready", 32'(in_ready),       32'd1);
      chk("arst.drop",     32'(drop_cnt),       32'd0);
      chk("arst.tmo",      32'(tmo_cnt),        32'd0);
      model_reset();
      @(posedge clock);
      #2;
      reset = 1'b1;
      @(negedge clock);
      check_all("arst_release");
      for (int i = 0; i < 6; i++) begin
         step("arst_quiet", 1'b0, 16'h0000, 1'b0);
         chk("arst_quiet.valid", 32'(issue_valid), 32'd0);
      end
      chk("arst_quiet.busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
